// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multicycle MIPS-subset core: controller state,
// PC source select, opcode encoding and the legal-opcode check.
package mc_controller_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEM       = 3'd4,
        WRITEBACK = 3'd5,
        HALTED    = 3'd6,
        ERROR     = 3'd7
    } ctrl_state_e;

    typedef enum logic [1:0] {
        PC_INC    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2
    } pc_sel_e;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B,
        OP_HALT  = 6'h3F
    } opcode_e;

    // True for every opcode the controller knows how to sequence.
    function automatic logic is_legal(opcode_e op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI,
            OP_LW, OP_SW, OP_HALT: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller.sv
// Multicycle sequencing controller: steps each instruction through
// fetch / decode / execute / memory / writeback and drives the PC, IR,
// register-file write strobe and the shared memory port.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start, all outputs quiet
// FETCH     | instruction read from memory at PC; IR/PC load on ready
// DECODE    | register-file read; opcode classified
// EXECUTE   | ALU cycle; branches and jumps resolve here
// MEM       | data load/store at ALU result address
// WRITEBACK | register-file write strobe for one cycle
// HALTED    | HALT retired; held until reset
// ERROR     | illegal opcode or memory timeout; held until reset
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        ir_load,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        rf_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        busy,
    output logic        error,
    output logic [2:0]  state_o,
    output logic [31:0] instr_count
);

    localparam int WW = $clog2(MEM_TIMEOUT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

    ctrl_state_e   state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [31:0]   count_q, count_d;
    logic          retire;
    pc_sel_e       pc_sel_d;
    opcode_e       opcode;

    // Only the opcode field matters here; the rest of IR belongs to the datapath.
    logic unused_instr;
    assign unused_instr = ^instr[25:0];

    assign opcode = opcode_e'(instr[31:26]);

    // Next-state, wait-counter, retire and per-state control outputs.
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        count_d      = count_q;
        retire       = 1'b0;
        ir_load      = 1'b0;
        pc_en        = 1'b0;
        pc_sel_d     = PC_INC;
        rf_write     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_en   = 1'b1;
                    state_d = DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ERROR;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            DECODE: begin
                if (opcode == OP_HALT) begin
                    retire  = 1'b1;
                    state_d = HALTED;
                end else if (!is_legal(opcode)) begin
                    state_d = ERROR;
                end else begin
                    state_d = EXECUTE;
                end
            end
            EXECUTE: begin
                case (opcode)
                    OP_BEQ: begin
                        pc_en    = zero;
                        pc_sel_d = PC_BRANCH;
                        retire   = 1'b1;
                        state_d  = FETCH;
                    end
                    OP_J: begin
                        pc_en    = 1'b1;
                        pc_sel_d = PC_JUMP;
                        retire   = 1'b1;
                        state_d  = FETCH;
                    end
                    OP_LW, OP_SW:      state_d = MEM;
                    OP_RTYPE, OP_ADDI: state_d = WRITEBACK;
                    // IR is held stable, so this only fires if it was corrupted.
                    default:           state_d = ERROR;
                endcase
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode == OP_SW);
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ERROR;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            WRITEBACK: begin
                rf_write = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            default: begin
                // HALTED and ERROR hold until reset.
                state_d = state_q;
            end
        endcase

        // Every state change clears the wait counter, so FETCH and MEM start at 0.
        if (state_d != state_q) wait_d = '0;
        if (retire) count_d = count_q + 32'd1;
    end

    // State, wait counter and retired-instruction counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    assign pc_sel      = pc_sel_d;
    assign busy        = (state_q != IDLE) && (state_q != HALTED) && (state_q != ERROR);
    assign error       = (state_q == ERROR);
    assign state_o     = state_q;
    assign instr_count = count_q;

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle sequencing controller for the MIPS-subset core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the register-file write strobe into the decode stage, the PC update, the instruction-register load, and the shared instruction/data memory port. It sits beside the datapath and sees only the latched instruction, the execute-stage zero flag and the memory handshake.

## Interface
- MEM_TIMEOUT, 16: max cycles a memory request may wait for `mem_ready` before ERROR; ≥2.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  leave IDLE and begin fetching; ignored unless in IDLE.
- instr  in  32  Instruction; latched IR contents, valid from DECODE onward.
- zero  in  1  execute-stage rs==rt flag, valid in EXECUTE.
- mem_ready  in  1  memory completes the current request this cycle.
- ir_load  out  1  load IR from memory read data.
- pc_en  out  1  update PC this cycle.
- pc_sel  out  2  PcSel: PC_INC=0 (PC+4), PC_BRANCH=1, PC_JUMP=2.
- rf_write  out  1  register-file write strobe (decode-stage `write`).
- mem_req  out  1  memory request valid.
- mem_we  out  1  store when 1, load when 0; meaningful only with mem_req.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- busy  out  1  state is not IDLE, HALTED or ERROR.
- error  out  1  sticky; illegal opcode or memory timeout.
- state_o  out  3  CtrlState, for debug.
- instr_count  out  32  retired instructions; wraps 2^32-1 → 0.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALTED, ERROR.
- Opcodes: RTYPE=6'h00, J=6'h02, BEQ=6'h04, ADDI=6'h08, LW=6'h23, SW=6'h2B, HALT=6'h3F.
- IDLE: all outputs 0. `start` → FETCH.
- FETCH:
  - Drive mem_req=1, mem_we=0, mem_addr_sel=0.
  - On mem_ready: ir_load=1, pc_en=1, pc_sel=PC_INC, then go to DECODE.
- DECODE: one cycle for register-file read.
  - HALT → HALTED, counted as retired.
  - Unknown opcode → ERROR.
  - All other opcodes → EXECUTE.
- EXECUTE: one cycle.
  - BEQ: pc_en=zero, pc_sel=PC_BRANCH, retire, → FETCH.
  - J: pc_en=1, pc_sel=PC_JUMP, retire, → FETCH.
  - LW/SW → MEM.
  - RTYPE/ADDI → WRITEBACK.
- MEM:
  - Drive mem_req=1, mem_addr_sel=1, mem_we=(opcode==SW).
  - On mem_ready: LW → WRITEBACK; SW retires → FETCH.
- WRITEBACK: rf_write=1 for one cycle, retire, → FETCH.
- Timeout: a wait counter clears on entry to FETCH or MEM and increments each cycle mem_ready is low. When it reaches MEM_TIMEOUT-1 with mem_ready still low, go to ERROR. If mem_ready is high in that same cycle, the request completes normally.
- HALTED and ERROR hold until reset; `start` is ignored there. error=1 only in ERROR.
- Opcode is taken from instr[31:26] every cycle from DECODE on. The datapath holds IR stable because ir_load is 0 outside FETCH.
- Reset from any state, including mid-request: next state IDLE, instr_count=0, wait counter=0. A dropped memory request is not reissued.

## Timing
- Reset values: every output 0, state_o=IDLE.
- mem_req, mem_we, mem_addr_sel, rf_write and busy are Moore outputs (decoded from state).
- ir_load and pc_en in FETCH are Mealy outputs: same cycle as mem_ready.
- Cycles per instruction with mem_ready high on the first request cycle:
  - BEQ 3, J 3.
  - RTYPE 4, ADDI 4, SW 4.
  - LW 5.
  - Each wait cycle adds 1 to FETCH or MEM.
- instr_count increments on the edge that leaves the retiring state and is visible the following cycle.
- start pulse at edge N: mem_req is high in cycle N+1.

## Structure
- Add to the shared definitions package:
  - CtrlState enum (3 bits) and PcSel enum (2 bits).
  - HALT added to OpCode.
  - Function `is_legal(OpCode)`.
- Single module, no sub-modules. The wait counter is $clog2(MEM_TIMEOUT) bits, sized for values up to MEM_TIMEOUT-1.

## Test plan
- Reset, then start, then ADDI (0x2001_0005) with zero-wait memory → state sequence FETCH, DECODE, EXECUTE, WRITEBACK; rf_write high exactly 1 cycle; instr_count=1.
- LW (0x8C22_0004) with mem_ready delayed 3 cycles in MEM → mem_req high 4 MEM cycles with mem_addr_sel=1 and mem_we=0; 8 cycles total.
- BEQ with zero=1, then BEQ with zero=0 → pc_en in EXECUTE is 1 with pc_sel=1, then 0; no rf_write.
- mem_ready held low in FETCH, MEM_TIMEOUT=4 → ERROR after 4 FETCH cycles; error=1; busy=0; start ignored.
- Opcode 6'h3F → HALTED, instr_count incremented. Opcode 6'h11 → ERROR, count unchanged.
- Reset asserted during MEM of a SW → next cycle IDLE, all outputs 0, instr_count=0. A later start refetches.
